adc_serial_responder: RTL and testbench

- Synthesizable responder (ADC emulator) for the serial ADC link: the device end of the SCLK/TFS/RFS/data protocol driven by the team's ADC controller.
- Receives 16-bit control words on DIN during TFS frames and returns 16-bit sample words on DOUT during RFS frames.
- Sample words come from per-channel pattern generators, so the localization datapath (controller, channel memories, FIR) can be exercised in loopback on a spare GPIO header without the physical ADC.
- All link inputs are oversampled in the CLOCK_50 domain.

---
 rtl/adc_serial_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_serial_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_responder.sv
// ADC emulator for the serial ADC link.
// Captures 16-bit control words on din during TFS frames. Returns a 16-bit
// sample word {channel, pad, sample} on dout during RFS frames.
// All link pins are oversampled in the CLOCK_50 domain.
module adc_serial_responder #(
    parameter int WORD_W    = 16,
    parameter int DATA_W    = 11,
    parameter int RAMP_STEP = 1,
    parameter int CH_OFFSET = 256
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     sclk,
    input  logic                     tfs,
    input  logic                     rfs,
    input  logic                     din,
    input  logic [1:0]               pattern_sel,
    input  logic signed [DATA_W-1:0] ext_sample,
    output logic                     dout,
    output logic [WORD_W-1:0]        ctrl_word,
    output logic                     ctrl_valid,
    output logic [1:0]               cur_ch,
    output logic                     frame_err,
    output logic [15:0]              tx_count
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int PAD_W = WORD_W - 2 - DATA_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_DONE, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_WAIT} tx_state_t;

    // Reset value of a channel ramp: n*CH_OFFSET truncated to the sample width.
    function automatic logic signed [DATA_W-1:0] ramp_init(input int n);
        return DATA_W'(n * CH_OFFSET);
    endfunction

    // Ramp advance with two's complement wrap (max + 1 becomes min).
    function automatic logic signed [DATA_W-1:0] ramp_next(input logic signed [DATA_W-1:0] v);
        return v + DATA_W'(RAMP_STEP);
    endfunction

    // Alternating pattern: full-scale positive, or full-scale negative when neg is set.
    function automatic logic signed [DATA_W-1:0] alt_value(input logic neg);
        return neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    // Link synchronizers. They are deliberately left out of reset, so a sync
    // line held low across reset does not produce a falling edge afterwards.
    logic [2:0] sclk_q, tfs_q, rfs_q;
    logic [1:0] din_q;

    // Shift every link input through its synchronizer chain.
    always_ff @(posedge CLOCK_50) begin
        sclk_q <= {sclk_q[1:0], sclk};
        tfs_q  <= {tfs_q[1:0], tfs};
        rfs_q  <= {rfs_q[1:0], rfs};
        din_q  <= {din_q[0], din};
    end

    logic sclk_rise, sclk_fall, tfs_fall, rfs_fall, tfs_hi, rfs_hi, din_s;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign tfs_fall  = ~tfs_q[1] & tfs_q[2];
    assign rfs_fall  = ~rfs_q[1] & rfs_q[2];
    assign tfs_hi    = tfs_q[1];
    assign rfs_hi    = rfs_q[1];
    assign din_s     = din_q[1];

    // Control receive path state.
    rx_state_t         rx_state_q;
    logic [CNT_W-1:0]  rx_cnt_q;
    logic [WORD_W-1:0] rx_sh_q;
    logic [WORD_W-1:0] ctrl_word_q;
    logic              ctrl_valid_q;
    logic [1:0]        cur_ch_q;
    logic              rx_last, rx_abort;

    // The 16th falling edge wins over a simultaneous release of tfs.
    assign rx_last  = (rx_state_q == RX_SHIFT) && sclk_fall && (rx_cnt_q == LAST_BIT);
    assign rx_abort = (rx_state_q == RX_SHIFT) && tfs_hi && !rx_last;

    // RX FSM: shift din on SCLK falls and publish the complete control word.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            ctrl_word_q  <= '0;
            ctrl_valid_q <= 1'b0;
            cur_ch_q     <= 2'd0;
        end else begin
            ctrl_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (tfs_fall) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    if (sclk_fall) begin
                        rx_sh_q  <= {rx_sh_q[WORD_W-2:0], din_s};
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                    if (rx_last) begin
                        rx_state_q <= RX_DONE;
                    end else if (rx_abort) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                RX_DONE: begin
                    ctrl_word_q  <= rx_sh_q;
                    cur_ch_q     <= rx_sh_q[WORD_W-2 -: 2];
                    ctrl_valid_q <= 1'b1;
                    rx_state_q   <= RX_WAIT;
                end
                RX_WAIT: begin
                    if (tfs_hi) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Data transmit path state and pattern generators.
    tx_state_t                tx_state_q;
    logic [CNT_W-1:0]         tx_cnt_q;
    logic [WORD_W-1:0]        tx_sh_q;
    logic [1:0]               tx_ch_q;
    logic [1:0]               tx_pat_q;
    logic                     dout_q;
    logic [15:0]              tx_count_q;
    logic signed [DATA_W-1:0] ramp_q [4];
    logic                     alt_q;
    logic signed [DATA_W-1:0] sample_d;
    logic [WORD_W-1:0]        tx_word_d;
    logic                     tx_last, tx_abort;

    assign tx_last  = (tx_state_q == TX_SHIFT) && sclk_fall && (tx_cnt_q == LAST_BIT);
    assign tx_abort = (tx_state_q == TX_SHIFT) && rfs_hi && !tx_last;

    // Select the sample source for the word being snapshotted at LOAD.
    always_comb begin
        sample_d = '0;
        case (pattern_sel)
            2'b00:   sample_d = ramp_q[cur_ch_q];
            2'b01:   sample_d = ext_sample;
            2'b10:   sample_d = alt_value(alt_q);
            default: sample_d = '0;
        endcase
    end

    assign tx_word_d = {cur_ch_q, {PAD_W{1'b0}}, sample_d};

    // TX FSM: the counter counts SCLK falls, i.e. bits already taken by the
    // controller, so a rise before the first fall simply re-presents the MSB.
    // A completed frame advances only the generator that produced its sample.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            dout_q     <= 1'b0;
            tx_count_q <= 16'd0;
            alt_q      <= 1'b0;
            for (int n = 0; n < 4; n++) ramp_q[n] <= ramp_init(n);
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (rfs_fall) tx_state_q <= TX_LOAD;
                end
                TX_LOAD: begin
                    tx_sh_q    <= tx_word_d;
                    tx_ch_q    <= cur_ch_q;
                    tx_pat_q   <= pattern_sel;
                    dout_q     <= tx_word_d[WORD_W-1];
                    tx_cnt_q   <= '0;
                    tx_state_q <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (tx_last) begin
                        tx_count_q <= tx_count_q + 16'd1;
                        if (tx_pat_q == 2'b00) ramp_q[tx_ch_q] <= ramp_next(ramp_q[tx_ch_q]);
                        if (tx_pat_q == 2'b10) alt_q <= ~alt_q;
                        dout_q     <= 1'b0;
                        tx_state_q <= TX_WAIT;
                    end else if (tx_abort) begin
                        dout_q     <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        if (sclk_rise) dout_q <= tx_sh_q[WORD_W-1];
                        if (sclk_fall) begin
                            tx_sh_q  <= tx_sh_q << 1;
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                TX_WAIT: begin
                    dout_q <= 1'b0;
                    if (rfs_hi) tx_state_q <= TX_IDLE;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    logic frame_err_q;

    // Merge RX and TX aborts into one pulse; simultaneous aborts give a single pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) frame_err_q <= 1'b0;
        else          frame_err_q <= rx_abort | tx_abort;
    end

    assign dout       = dout_q;
    assign ctrl_word  = ctrl_word_q;
    assign ctrl_valid = ctrl_valid_q;
    assign cur_ch     = cur_ch_q;
    assign frame_err  = frame_err_q;
    assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder. It acts as the ADC controller and checks
// the DUT against a reference model of the channel generators.
module tb_adc_serial_responder;
    localparam int HALF = 4;  // CLOCK_50 cycles per SCLK half period

    logic               CLOCK_50 = 1'b0;
    logic               reset_n = 1'b0;
    logic               sclk = 1'b0;
    logic               tfs = 1'b1;
    logic               rfs = 1'b1;
    logic               din = 1'b0;
    logic [1:0]         pattern_sel = 2'b00;
    logic signed [10:0] ext_sample = '0;
    logic               dout;
    logic [15:0]        ctrl_word;
    logic               ctrl_valid;
    logic [1:0]         cur_ch;
    logic               frame_err;
    logic [15:0]        tx_count;

    adc_serial_responder dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .tfs         (tfs),
        .rfs         (rfs),
        .din         (din),
        .pattern_sel (pattern_sel),
        .ext_sample  (ext_sample),
        .dout        (dout),
        .ctrl_word   (ctrl_word),
        .ctrl_valid  (ctrl_valid),
        .cur_ch      (cur_ch),
        .frame_err   (frame_err),
        .tx_count    (tx_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    // Reference model state.
    int          m_ramp [4];
    bit          m_alt;
    int          m_ch;
    logic [15:0] m_cw;
    int          m_cnt;

    // Count the high cycles of each pulse output.
    always @(negedge CLOCK_50) begin
        if (ctrl_valid) n_valid++;
        if (frame_err)  n_err++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_ramp[n] = (n * 256) % 2048;
        m_alt = 1'b0;
        m_ch  = 0;
        m_cw  = 16'h0000;
        m_cnt = 0;
    endtask

    function automatic logic [15:0] model_word(input int ch, input logic [1:0] pat,
                                               input logic signed [10:0] ext);
        logic [10:0] s;
        case (pat)
            2'd0:    s = 11'(m_ramp[ch]);
            2'd1:    s = ext;
            2'd2:    s = m_alt ? 11'h400 : 11'h3FF;
            default: s = 11'h000;
        endcase
        return {2'(ch), 3'b000, s};
    endfunction

    // One link transaction. A control frame, a data frame, or both overlap.
    // Each frame lasts *_bits SCLK cycles; 16 bits means a complete frame.
    task automatic run_frame(input bit do_rx, input int rx_bits, input logic [15:0] cw,
                             input bit do_tx, input int tx_bits, output logic [15:0] got);
        logic [15:0] exp_w;
        int          v0, e0, nb, exp_err;
        bit          rx_full, tx_full, rx_ab, tx_ab;
        exp_w   = model_word(m_ch, pattern_sel, ext_sample);
        got     = 16'h0000;
        rx_full = do_rx && (rx_bits == 16);
        tx_full = do_tx && (tx_bits == 16);
        rx_ab   = do_rx && (rx_bits < 16);
        tx_ab   = do_tx && (tx_bits < 16);
        nb = 0;
        if (do_rx && rx_bits > nb) nb = rx_bits;
        if (do_tx && tx_bits > nb) nb = tx_bits;
        @(negedge CLOCK_50);
        v0 = n_valid;
        e0 = n_err;
        if (do_rx) tfs = 1'b0;
        if (do_tx) rfs = 1'b0;
        if (do_tx) begin
            repeat (3) @(negedge CLOCK_50);
            check_eq("dout_before_load", dout, 0);
            @(negedge CLOCK_50);
            check_eq("dout_msb_latency", dout, exp_w[15]);
            repeat (2) @(negedge CLOCK_50);
        end else begin
            repeat (6) @(negedge CLOCK_50);
        end
        for (int i = 0; i < nb; i++) begin
            sclk = 1'b1;
            din  = cw[15-i];
            repeat (HALF) @(negedge CLOCK_50);
            if (tx_full) got[15-i] = dout;
            sclk = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            if (do_rx && i + 1 == rx_bits) tfs = 1'b1;
            if (do_tx && i + 1 == tx_bits) rfs = 1'b1;
        end
        tfs = 1'b1;
        rfs = 1'b1;
        din = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        if (tx_full) begin
            check_eq("tx_word", got, exp_w);
            m_cnt = (m_cnt + 1) % 65536;
            if (pattern_sel == 2'd0) m_ramp[m_ch] = (m_ramp[m_ch] + 1) % 2048;
            if (pattern_sel == 2'd2) m_alt = !m_alt;
        end
        if (rx_full) begin
            m_cw = cw;
            m_ch = int'(cw[14:13]);
        end
        exp_err = (rx_ab && tx_ab && rx_bits == tx_bits) ? 1 : int'(rx_ab) + int'(tx_ab);
        check_eq("ctrl_valid_pulses", n_valid - v0, int'(rx_full));
        check_eq("frame_err_pulses", n_err - e0, exp_err);
        check_eq("tx_count", tx_count, m_cnt);
        check_eq("ctrl_word", ctrl_word, m_cw);
        check_eq("cur_ch", cur_ch, m_ch);
        check_eq("dout_idle", dout, 0);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] cw;
        bit          do_rx, do_tx;
        int          rb, tb_bits, e0, v0;

        model_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_ctrl_word", ctrl_word, 0);
        check_eq("rst_ctrl_valid", ctrl_valid, 0);
        check_eq("rst_cur_ch", cur_ch, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_tx_count", tx_count, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Control word selecting channel 2.
        run_frame(1, 16, 16'hC000, 0, 0, w);
        check_eq("sel_ch2_word", ctrl_word, 16'hC000);
        check_eq("sel_ch2_ch", cur_ch, 2);

        // Three ramp frames on channel 2.
        pattern_sel = 2'b00;
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("ramp_f1", w, 16'h8200);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("ramp_f2", w, 16'h8201);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("ramp_f3", w, 16'h8202);
        check_eq("ramp_count3", tx_count, 3);

        // Data frame released after 9 SCLKs, then a full frame repeats the sample.
        run_frame(0, 0, 16'h0000, 1, 9, w);
        check_eq("abort_count", tx_count, 3);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("after_abort", w, 16'h8203);

        // Channel 0, then a control frame for channel 1 overlapping a data frame.
        run_frame(1, 16, 16'h0000, 0, 0, w);
        run_frame(1, 16, 16'h2000, 1, 16, w);
        check_eq("overlap_cur", w, 16'h0000);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("overlap_next", w, 16'h4100);

        // Alternating pattern on channel 1.
        pattern_sel = 2'b10;
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("alt_pos", w[10:0], 11'h3FF);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("alt_neg", w[10:0], 11'h400);

        // Simultaneous and separate aborts of both frames.
        run_frame(1, 5, 16'hFFFF, 1, 5, w);
        run_frame(1, 3, 16'hFFFF, 1, 7, w);

        // Ramp wrap on channel 3: 768 counts up to 1023, then wraps to -1024.
        pattern_sel = 2'b00;
        run_frame(1, 16, 16'h6000, 0, 0, w);
        for (int k = 0; k < 255; k++) run_frame(0, 0, 16'h0000, 1, 16, w);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("wrap_max", w, 16'hC3FF);
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("wrap_min", w, 16'hC400);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            ext_sample  = 11'($urandom);
            cw          = 16'($urandom);
            do_rx       = 1'($urandom_range(0, 1));
            do_tx       = do_rx ? 1'($urandom_range(0, 1)) : 1'b1;
            rb          = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            tb_bits     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_frame(do_rx, rb, cw, do_tx, tb_bits, w);
        end

        // Reset in the middle of overlapping frames.
        pattern_sel = 2'b00;
        @(negedge CLOCK_50);
        e0  = n_err;
        v0  = n_valid;
        tfs = 1'b0;
        rfs = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1;
            din  = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge CLOCK_50);
            sclk = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
        end
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        model_reset();
        check_eq("midrst_dout", dout, 0);
        check_eq("midrst_tx_count", tx_count, 0);
        check_eq("midrst_cur_ch", cur_ch, 0);
        for (int i = 0; i < 11; i++) begin
            sclk = 1'b1;
            din  = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge CLOCK_50);
            sclk = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
        end
        check_eq("midrst_dout_held", dout, 0);
        tfs = 1'b1;
        rfs = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check_eq("midrst_no_err", n_err - e0, 0);
        check_eq("midrst_no_valid", n_valid - v0, 0);
        check_eq("midrst_ctrl_word", ctrl_word, 0);

        // Generators restart from their reset values.
        pattern_sel = 2'b10;
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("post_rst_alt", w, 16'h03FF);
        pattern_sel = 2'b00;
        run_frame(0, 0, 16'h0000, 1, 16, w);
        check_eq("post_rst_ramp", w, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
